// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for mem_arbiter and its grant picker.
// ADDR_WIDTH is normally provided by the project; a 32-bit fallback keeps this slice self-contained.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mem_arbiter_pkg;

  localparam int ADDR_W     = `ADDR_WIDTH;
  localparam int LINE_WIDTH = 256;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: data side wins ties unless fetch has been starved to the limit.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_valid,
  output owner_t           grant_owner
);

  // Pick the owner of the next memory transaction.
  always_comb begin
    grant_valid = i_req | d_req;
    if (i_req && (!d_req || (starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
      grant_owner = OWN_I;
    end else begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-memory port between fetch (i_*) and data (d_*) requesters.
// Define ARB_TIMEOUT_EN to abort a memory op not acked within TIMEOUT cycles (acked with err=1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W       = LINE_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              err_q, err_d;
  logic              resp_s;
  logic [LINE_W-1:0] resp_data_s;
  logic              grant_valid;
  owner_t            grant_owner;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 0);
`endif

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt_q),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // Next-state and next-output computation for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = 1'b0;
    resp_s       = 1'b0;
    resp_data_s  = mem_rdata;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d   = ARB_BUSY;
          owner_d   = grant_owner;
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_d     = {TMO_W{1'b0}};
`endif
          if (grant_owner == OWN_I) begin
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr;
            mem_wdata_d  = {LINE_W{1'b0}};
            starve_cnt_d = {CNT_W{1'b0}};
          end else begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (i_req) begin
              starve_cnt_d = sat_inc(starve_cnt_q, CNT_W'(STARVE_LIMIT));
            end else begin
              starve_cnt_d = starve_cnt_q;
            end
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (mem_ack) begin
          resp_s      = 1'b1;
          resp_data_s = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Abort: the owner is still acked so it never hangs, but sees zero data and err.
          resp_s      = 1'b1;
          resp_data_s = {LINE_W{1'b0}};
          err_d       = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`else
        end else begin
          resp_s = 1'b0;
`endif
        end
        if (resp_s) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data_s;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data_s;
          end
        end else begin
          state_d = ARB_BUSY;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {LINE_W{1'b0}};
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= {LINE_W{1'b0}};
      d_rdata_q    <= {LINE_W{1'b0}};
      starve_cnt_q <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small auto-responding memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LW = 256;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [LW-1:0]     i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LW-1:0]     d_wdata;
  logic              d_ack;
  logic [LW-1:0]     d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [LW-1:0]     mem_rdata;
  logic              err;

  logic              mem_ack_auto;
  logic              mem_ack_man;
  logic              mem_auto;
  int                mem_delay;
  int                mem_wait;
  logic [LW-1:0]     mem_pat;
  logic [LW-1:0]     pat_i;

  int total;
  int bad;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .LINE_W      (LW),
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  // Memory model: acks mem_delay cycles after it first sees mem_req high.
  always @(posedge CLK) begin
    #1;
    if (mem_ack_auto) begin
      mem_ack_auto = 1'b0;
      mem_wait     = 0;
    end else if (mem_auto && mem_req) begin
      if (mem_wait >= mem_delay) mem_ack_auto = 1'b1;
      else mem_wait = mem_wait + 1;
    end else begin
      mem_wait = 0;
    end
  end

  assign mem_ack   = mem_ack_auto | mem_ack_man;
  assign mem_rdata = mem_pat;

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== {LW{1'b0}}) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if ({i_ack, d_ack, err} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", {i_ack, d_ack, err}); end
    total++; if (i_rdata !== {LW{1'b0}}) begin bad++; $display("FAIL reset_i_rdata got=%h exp=0", i_rdata); end
    total++; if (d_rdata !== {LW{1'b0}}) begin bad++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_d_read();
    int t_req;
    int t_ack;
    int n_iack;
    mem_pat = {32{8'hA5}}; mem_delay = 2; mem_auto = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    t_req = -1; t_ack = -1; n_iack = 0;
    for (int c = 1; c <= 20 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (i_ack) n_iack++;
      if (mem_req && t_req < 0) begin
        t_req = c;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%0b exp=0", mem_we); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL rd_mem_addr got=%h exp=40", mem_addr); end
      end
      if (d_ack) begin
        t_ack = c;
        d_req = 1'b0;
        total++; if (d_rdata !== {32{8'hA5}}) begin bad++; $display("FAIL rd_d_rdata got=%h exp=a5..", d_rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0b exp=0", err); end
      end
    end
    d_req = 1'b0;
    total++; if (t_req !== 1) begin bad++; $display("FAIL rd_req_latency got=%0d exp=1", t_req); end
    total++; if (t_ack !== 4) begin bad++; $display("FAIL rd_ack_latency got=%0d exp=4", t_ack); end
    @(negedge CLK);
    if (i_ack) n_iack++;
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_width got=%0b exp=0", d_ack); end
    total++; if (n_iack !== 0) begin bad++; $display("FAIL rd_no_iack got=%0d exp=0", n_iack); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_order;
    int k;
    int dbl;
    logic prev;
    exp_order = 10'b1111011110;
    mem_delay = 0; mem_auto = 1'b1;
    i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    k = 0; dbl = 0; prev = 1'b0;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge CLK);
      if ((i_ack || d_ack) && prev) dbl++;
      if (i_ack && d_ack) dbl++;
      prev = i_ack | d_ack;
      if (i_ack || d_ack) begin
        total++;
        if (d_ack !== exp_order[9-k]) begin
          bad++; $display("FAIL grant_order idx=%0d got_d=%0b exp_d=%0b", k, d_ack, exp_order[9-k]);
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err idx=%0d got=%0b exp=0", k, err); end
        k++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++; if (k !== 10) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=10", k); end
    total++; if (dbl !== 0) begin bad++; $display("FAIL b2b_double_ack got=%0d exp=0", dbl); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_write_hold();
    logic [LW-1:0] w0;
    int n_ack;
    logic seen;
    w0 = {8{32'h1234_5678}};
    mem_delay = 3; mem_auto = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = w0;
    n_ack = 0; seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (mem_req) begin
        if (!seen) begin
          seen = 1'b1; d_wdata = ~w0; d_addr = 32'h99; d_we = 1'b0;
        end
        total++;
        if (mem_wdata !== w0 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
          bad++; $display("FAIL wr_hold cyc=%0d got we=%0b addr=%h data=%h exp we=1 addr=80 data=%h",
                          c, mem_we, mem_addr, mem_wdata, w0);
        end
      end
      if (d_ack) begin n_ack++; d_req = 1'b0; end
    end
    d_req = 1'b0;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL wr_mem_req_seen got=%0b exp=1", seen); end
    total++; if (n_ack !== 1) begin bad++; $display("FAIL wr_ack_count got=%0d exp=1", n_ack); end
  endtask

  task automatic test_reset_busy();
    logic seen;
    int n;
    int t_ack;
    mem_auto = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (mem_req) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rb_busy_reached got=%0b exp=1", seen); end
    RST = 1'b1; d_req = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rb_mem_req_drop got=%0b exp=0", mem_req); end
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (i_ack || d_ack || mem_req) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL rb_no_ack got=%0d exp=0", n); end
    pat_i = {8{32'hC3C3_0F0F}};
    mem_pat = pat_i; mem_delay = 1; mem_auto = 1'b1;
    i_req = 1'b1; i_addr = 32'h300;
    seen = 1'b0; t_ack = -1;
    for (int c = 1; c <= 20 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (mem_req && !seen) begin
        seen = 1'b1;
        total++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) begin
          bad++; $display("FAIL rb_i_mem got addr=%h we=%0b exp addr=300 we=0", mem_addr, mem_we);
        end
      end
      if (d_ack) begin bad++; total++; $display("FAIL rb_stray_d_ack got=1 exp=0"); end
      if (i_ack) begin
        t_ack = c; i_req = 1'b0;
        total++; if (i_rdata !== pat_i) begin bad++; $display("FAIL rb_i_rdata got=%h exp=%h", i_rdata, pat_i); end
      end
    end
    i_req = 1'b0;
    total++; if (t_ack !== 3) begin bad++; $display("FAIL rb_i_latency got=%0d exp=3", t_ack); end
    @(negedge CLK);
  endtask

  task automatic test_spurious();
    int n;
    int t_req;
    int t_ack;
    logic [LW-1:0] p3;
    mem_auto = 1'b0;
    mem_pat = {64{4'h7}};
    @(negedge CLK);
    mem_ack_man = 1'b1;
    @(negedge CLK);
    mem_ack_man = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge CLK);
      if (i_ack || d_ack || mem_req) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL sp_no_activity got=%0d exp=0", n); end
    total++; if (d_rdata !== {LW{1'b0}}) begin bad++; $display("FAIL sp_d_rdata got=%h exp=0", d_rdata); end
    total++; if (i_rdata !== pat_i) begin bad++; $display("FAIL sp_i_rdata got=%h exp=%h", i_rdata, pat_i); end
    p3 = {4{64'h0123_4567_89AB_CDEF}};
    mem_pat = p3; mem_delay = 0; mem_auto = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    t_req = -1; t_ack = -1;
    for (int c = 1; c <= 20 && t_ack < 0; c++) begin
      @(negedge CLK);
      if (mem_req && t_req < 0) t_req = c;
      if (d_ack) begin
        t_ack = c; d_req = 1'b0;
        total++; if (d_rdata !== p3) begin bad++; $display("FAIL sp_next_rdata got=%h exp=%h", d_rdata, p3); end
      end
    end
    d_req = 1'b0;
    total++; if (t_req !== 1) begin bad++; $display("FAIL sp_next_req_latency got=%0d exp=1", t_req); end
    total++; if (t_ack !== 2) begin bad++; $display("FAIL sp_min_latency got=%0d exp=2", t_ack); end
    @(negedge CLK);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n_req;
    int got;
    mem_auto = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    n_req = 0; got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      @(negedge CLK);
      if (mem_req) n_req++;
      if (d_ack) begin
        got = 1; d_req = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%0b exp=1", err); end
        total++; if (d_rdata !== {LW{1'b0}}) begin bad++; $display("FAIL to_d_rdata got=%h exp=0", d_rdata); end
      end
    end
    d_req = 1'b0;
    total++; if (got !== 1) begin bad++; $display("FAIL to_ack_seen got=%0d exp=1", got); end
    total++; if (n_req !== 8) begin bad++; $display("FAIL to_req_cycles got=%0d exp=8", n_req); end
    @(negedge CLK);
    total++; if (err !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL to_after got err=%0b req=%0b exp 0 0", err, mem_req); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    RST = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = {LW{1'b0}};
    mem_ack_auto = 1'b0; mem_ack_man = 1'b0; mem_auto = 1'b0;
    mem_delay = 0; mem_wait = 0; mem_pat = {LW{1'b0}}; pat_i = {LW{1'b0}};
    test_reset();
    test_d_read();
    test_back_to_back();
    test_write_hold();
    test_reset_busy();
    test_spurious();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
